// File: rtl/tag_ram_pkg.sv
// Shared types and helpers for the N-way tag store.
package tag_ram_pkg;

   typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // Rotate the low n bits of v left by one position.
   function automatic logic [31:0] rotl1(input logic [31:0] v, input int unsigned n);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < n) r[(i + 1 == n) ? 0 : i + 1] = v[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/tag_way_ram.sv
// One way of the tag store: sync write, latched read address, combinational read.
module tag_way_ram #(
   parameter int AWIDTH = 3,
   parameter int TWIDTH = 7
) (
   input  logic              clock,
   input  logic              i_wr_en,
   input  logic [AWIDTH-1:0] i_wr_addr,
   input  logic [TWIDTH-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [AWIDTH-1:0] i_rd_addr,
   output logic [TWIDTH-1:0] o_rd_data
);

   logic [TWIDTH-1:0] r_mem [1<<AWIDTH];
   logic [AWIDTH-1:0] r_rd_addr;

   always_ff @(posedge clock) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_addr <= i_rd_addr;
   end

   // Read after the address latch so a same-edge write is seen (write-first).
   assign o_rd_data = r_mem[r_rd_addr];

endmodule

// File: rtl/tag_ram_nway_sync.sv
// N-way set-associative tag store with valid sweep, compare and round-robin victim.
module tag_ram_nway_sync
   import tag_ram_pkg::*;
#(
   parameter int AWIDTH = 3,
   parameter int TWIDTH = 7,
   parameter int WAYS   = 2
) (
   input  logic              clock,
   input  logic              rst_n,
   output logic              ready,
   input  logic              flush_req,
   input  logic              lk_en,
   input  logic [AWIDTH-1:0] lk_idx,
   input  logic [TWIDTH-1:0] lk_tag,
   output logic              lk_done,
   output logic              hit,
   output logic [WAYS-1:0]   hit_way,
   output logic              multi_hit,
   output logic [WAYS-1:0]   victim_way,
   input  logic              wr_en,
   input  logic [WAYS-1:0]   wr_way,
   input  logic [AWIDTH-1:0] wr_idx,
   input  logic [TWIDTH-1:0] wr_tag,
   input  logic              wr_valid
);

   localparam int SETS = 1 << AWIDTH;
   localparam int CW   = clog2(WAYS + 1);

   state_t            r_state, w_state_nxt;
   logic [AWIDTH-1:0] r_sweep_cnt, w_sweep_cnt_nxt;
   logic [WAYS-1:0]   r_valid [SETS];
   logic [WAYS-1:0]   r_rr    [SETS];
   logic              r_lk_done;
   logic [AWIDTH-1:0] r_lk_idx;
   logic [TWIDTH-1:0] r_lk_tag;
   logic              r_hit, r_multi;
   logic [WAYS-1:0]   r_hit_way, r_victim;

   logic              w_lk_acc, w_wr_acc;
   logic [TWIDTH-1:0] w_rd_tag [WAYS];
   logic [WAYS-1:0]   w_match, w_inv, w_hit_way, w_victim;
   logic [CW-1:0]     w_hit_cnt;
   logic              w_hit, w_multi;

   assign ready    = (r_state == ST_IDLE);
   assign w_lk_acc = ready && lk_en && !flush_req;
   assign w_wr_acc = ready && wr_en && !flush_req && ($countones(wr_way) == 1);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_SWEEP;
         r_sweep_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_sweep_cnt <= w_sweep_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_sweep_cnt_nxt = r_sweep_cnt;
      case (r_state)
         ST_SWEEP: begin
            if (r_sweep_cnt == '1) begin
               w_state_nxt     = ST_IDLE;
               w_sweep_cnt_nxt = '0;
            end else begin
               w_sweep_cnt_nxt = r_sweep_cnt + AWIDTH'(1);
            end
         end
         ST_IDLE: begin
            if (flush_req) begin
               w_state_nxt     = ST_SWEEP;
               w_sweep_cnt_nxt = '0;
            end
         end
         default: w_state_nxt = ST_SWEEP;
      endcase
   end

   // Valid bits and rr pointers are cleared only by the sweep, never by reset.
   always_ff @(posedge clock) begin
      if (r_state == ST_SWEEP) begin
         r_valid[r_sweep_cnt] <= '0;
         r_rr[r_sweep_cnt]    <= WAYS'(1);
      end else if (w_wr_acc) begin
         r_valid[wr_idx] <= (r_valid[wr_idx] & ~wr_way) | (wr_valid ? wr_way : '0);
         if (wr_valid) r_rr[wr_idx] <= WAYS'(rotl1(32'(r_rr[wr_idx]), WAYS));
      end
   end

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      tag_way_ram #(
         .AWIDTH (AWIDTH),
         .TWIDTH (TWIDTH)
      ) u_way (
         .clock     (clock),
         .i_wr_en   (w_wr_acc && wr_way[g]),
         .i_wr_addr (wr_idx),
         .i_wr_data (wr_tag),
         .i_rd_en   (w_lk_acc),
         .i_rd_addr (lk_idx),
         .o_rd_data (w_rd_tag[g])
      );
   end

   always_comb begin
      w_match = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         w_match[w] = r_valid[r_lk_idx][w] && (w_rd_tag[w] == r_lk_tag);
      end
      w_inv     = ~r_valid[r_lk_idx];
      w_hit_cnt = CW'($countones(w_match));
      w_hit     = (w_match != '0);
      w_multi   = (w_hit_cnt > CW'(1));
      w_hit_way = (WAYS == 1) ? '1 : (w_match & (~w_match + WAYS'(1)));
      w_victim  = (w_inv != '0) ? (w_inv & (~w_inv + WAYS'(1))) : r_rr[r_lk_idx];
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_lk_done <= 1'b0;
         r_lk_idx  <= '0;
         r_lk_tag  <= '0;
         r_hit     <= 1'b0;
         r_hit_way <= '0;
         r_multi   <= 1'b0;
         r_victim  <= '0;
      end else begin
         r_lk_done <= w_lk_acc;
         if (w_lk_acc) begin
            r_lk_idx <= lk_idx;
            r_lk_tag <= lk_tag;
         end
         if (r_lk_done) begin
            r_hit     <= w_hit;
            r_hit_way <= w_hit_way;
            r_multi   <= w_multi;
            r_victim  <= w_victim;
         end
      end
   end

   // Live compare result while lk_done is high, otherwise the captured copy.
   assign lk_done    = r_lk_done;
   assign hit        = r_lk_done ? w_hit     : r_hit;
   assign hit_way    = r_lk_done ? w_hit_way : r_hit_way;
   assign multi_hit  = r_lk_done ? w_multi   : r_multi;
   assign victim_way = r_lk_done ? w_victim  : r_victim;

endmodule

// File: tb/tb_tag_ram_nway_sync.sv
// Self-checking bench: directed vector table, hand sequences and random traffic vs a set/way model.
module tb_tag_ram_nway_sync;

   localparam int AW = 3;
   localparam int TW = 7;
   localparam int NW = 2;
   localparam int NS = 1 << AW;

   logic          clock, rst_n, ready, flush_req;
   logic          lk_en, lk_done, hit, multi_hit, wr_en, wr_valid;
   logic [AW-1:0] lk_idx, wr_idx;
   logic [TW-1:0] lk_tag, wr_tag;
   logic [NW-1:0] hit_way, victim_way, wr_way;

   int n_total = 0;
   int n_bad   = 0;

   logic [TW-1:0] m_tag   [NS][NW];
   bit            m_valid [NS][NW];
   int unsigned   m_rr    [NS];
   int            m_busy;
   bit            e_done, e_hit, e_multi;
   logic [NW-1:0] e_hw, e_vic;

   typedef struct {
      bit            le;
      logic [AW-1:0] li;
      logic [TW-1:0] lt;
      bit            we;
      logic [NW-1:0] ww;
      logic [AW-1:0] wi;
      logic [TW-1:0] wt;
      bit            wv;
      bit            chk;
      bit            hit;
      logic [NW-1:0] hw;
      bit            mh;
      logic [NW-1:0] vic;
   } vec_t;

   vec_t tbl [16];

   tag_ram_nway_sync #(
      .AWIDTH (AW),
      .TWIDTH (TW),
      .WAYS   (NW)
   ) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .ready      (ready),
      .flush_req  (flush_req),
      .lk_en      (lk_en),
      .lk_idx     (lk_idx),
      .lk_tag     (lk_tag),
      .lk_done    (lk_done),
      .hit        (hit),
      .hit_way    (hit_way),
      .multi_hit  (multi_hit),
      .victim_way (victim_way),
      .wr_en      (wr_en),
      .wr_way     (wr_way),
      .wr_idx     (wr_idx),
      .wr_tag     (wr_tag),
      .wr_valid   (wr_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int s = 0; s < NS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
      end
   endtask

   // One clock edge of behaviour, computed from the set/way rules.
   task automatic model_step(input bit le, input logic [AW-1:0] li, input logic [TW-1:0] lt,
                             input bit we, input logic [NW-1:0] ww, input logic [AW-1:0] wi,
                             input logic [TW-1:0] wt, input bit wv, input bit fl);
      int n, first, fi, way;
      e_done = 1'b0;
      if (m_busy > 0) begin
         m_busy--;
      end else if (fl) begin
         m_busy = NS;
         model_clear();
      end else begin
         if (we && $countones(ww) == 1) begin
            way = 0;
            for (int w = 0; w < NW; w++) if (ww[w]) way = w;
            m_tag[wi][way]   = wt;
            m_valid[wi][way] = wv;
            if (wv) m_rr[wi] = (m_rr[wi] + 1) % NW;
         end
         if (le) begin
            n = 0; first = -1; fi = -1;
            for (int w = 0; w < NW; w++) begin
               if (m_valid[li][w] && m_tag[li][w] == lt) begin
                  n++;
                  if (first < 0) first = w;
               end
               if (!m_valid[li][w] && fi < 0) fi = w;
            end
            e_done  = 1'b1;
            e_hit   = (n > 0);
            e_multi = (n > 1);
            e_hw    = (first >= 0) ? NW'(1 << first) : '0;
            e_vic   = (fi >= 0) ? NW'(1 << fi) : NW'(1 << m_rr[li]);
         end
      end
   endtask

   task automatic check_outputs();
      chk("ready", 32'(ready), 32'(m_busy == 0));
      chk("lk_done", 32'(lk_done), 32'(e_done));
      chk("hit", 32'(hit), 32'(e_hit));
      chk("hit_way", 32'(hit_way), 32'(e_hw));
      chk("multi_hit", 32'(multi_hit), 32'(e_multi));
      chk("victim_way", 32'(victim_way), 32'(e_vic));
   endtask

   task automatic cycle(input bit le, input logic [AW-1:0] li, input logic [TW-1:0] lt,
                        input bit we, input logic [NW-1:0] ww, input logic [AW-1:0] wi,
                        input logic [TW-1:0] wt, input bit wv, input bit fl);
      lk_en = le; lk_idx = li; lk_tag = lt;
      wr_en = we; wr_way = ww; wr_idx = wi; wr_tag = wt; wr_valid = wv;
      flush_req = fl;
      model_step(le, li, lt, we, ww, wi, wt, wv, fl);
      @(posedge clock);
      #1;
      lk_en = 1'b0; wr_en = 1'b0; flush_req = 1'b0;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, '0, 0, 0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      e_done = 1'b0; e_hit = 1'b0; e_multi = 1'b0; e_hw = '0; e_vic = '0;
      model_clear();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_lk_done", 32'(lk_done), 32'd0);
      chk("rst_hit", 32'(hit), 32'd0);
      chk("rst_hit_way", 32'(hit_way), 32'd0);
      chk("rst_multi", 32'(multi_hit), 32'd0);
      chk("rst_victim", 32'(victim_way), 32'd0);
      @(posedge clock);
      @(posedge clock);
      #1;
      rst_n  = 1'b1;
      m_busy = NS;
   endtask

   initial begin
      rst_n = 1'b1;
      lk_en = 1'b0; lk_idx = '0; lk_tag = '0;
      wr_en = 1'b0; wr_way = '0; wr_idx = '0; wr_tag = '0; wr_valid = 1'b0;
      flush_req = 1'b0;
      m_busy = 0;
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++) m_tag[s][w] = '0;

      //                le li    lt     we ww     wi    wt     wv chk hit hw     mh vic
      tbl[0]  = '{1, 3'd0, 7'h00, 0, 2'b00, 3'd0, 7'h00, 0, 1, 0, 2'b00, 0, 2'b01};
      tbl[1]  = '{0, 3'd0, 7'h00, 1, 2'b01, 3'd5, 7'h2A, 1, 0, 0, 2'b00, 0, 2'b00};
      tbl[2]  = '{1, 3'd5, 7'h2A, 0, 2'b00, 3'd0, 7'h00, 0, 1, 1, 2'b01, 0, 2'b10};
      tbl[3]  = '{0, 3'd0, 7'h00, 1, 2'b01, 3'd3, 7'h11, 1, 0, 0, 2'b00, 0, 2'b00};
      tbl[4]  = '{0, 3'd0, 7'h00, 1, 2'b10, 3'd3, 7'h22, 1, 0, 0, 2'b00, 0, 2'b00};
      tbl[5]  = '{1, 3'd3, 7'h33, 0, 2'b00, 3'd0, 7'h00, 0, 1, 0, 2'b00, 0, 2'b01};
      tbl[6]  = '{0, 3'd0, 7'h00, 1, 2'b01, 3'd3, 7'h11, 1, 0, 0, 2'b00, 0, 2'b00};
      tbl[7]  = '{1, 3'd3, 7'h33, 0, 2'b00, 3'd0, 7'h00, 0, 1, 0, 2'b00, 0, 2'b10};
      tbl[8]  = '{1, 3'd2, 7'h05, 1, 2'b10, 3'd2, 7'h05, 1, 1, 1, 2'b10, 0, 2'b01};
      tbl[9]  = '{0, 3'd0, 7'h00, 1, 2'b01, 3'd1, 7'h44, 1, 0, 0, 2'b00, 0, 2'b00};
      tbl[10] = '{0, 3'd0, 7'h00, 1, 2'b10, 3'd1, 7'h44, 1, 0, 0, 2'b00, 0, 2'b00};
      tbl[11] = '{1, 3'd1, 7'h44, 0, 2'b00, 3'd0, 7'h00, 0, 1, 1, 2'b01, 1, 2'b01};
      tbl[12] = '{0, 3'd0, 7'h00, 1, 2'b11, 3'd4, 7'h10, 1, 0, 0, 2'b00, 0, 2'b00};
      tbl[13] = '{1, 3'd4, 7'h10, 0, 2'b00, 3'd0, 7'h00, 0, 1, 0, 2'b00, 0, 2'b01};
      tbl[14] = '{0, 3'd0, 7'h00, 1, 2'b01, 3'd5, 7'h2A, 0, 0, 0, 2'b00, 0, 2'b00};
      tbl[15] = '{1, 3'd5, 7'h2A, 0, 2'b00, 3'd0, 7'h00, 0, 1, 0, 2'b00, 0, 2'b01};

      apply_reset();
      // Initial sweep: lookups are dropped and ready stays low for NS cycles.
      for (int i = 0; i < NS; i++) cycle(1, AW'(i), '0, 0, '0, '0, '0, 0, 0);
      chk("ready_after_sweep", 32'(ready), 32'd1);

      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].le, tbl[i].li, tbl[i].lt, tbl[i].we, tbl[i].ww,
               tbl[i].wi, tbl[i].wt, tbl[i].wv, 0);
         if (tbl[i].chk) begin
            chk($sformatf("tbl%0d_done", i), 32'(lk_done), 32'd1);
            chk($sformatf("tbl%0d_hit", i), 32'(hit), 32'(tbl[i].hit));
            chk($sformatf("tbl%0d_hit_way", i), 32'(hit_way), 32'(tbl[i].hw));
            chk($sformatf("tbl%0d_multi", i), 32'(multi_hit), 32'(tbl[i].mh));
            chk($sformatf("tbl%0d_victim", i), 32'(victim_way), 32'(tbl[i].vic));
         end
      end
      idle(2);

      // Flush with a same-cycle write and lookup: both dropped, sweep starts.
      cycle(1, 3'd3, 7'h11, 1, 2'b01, 3'd6, 7'h6A, 1, 1);
      chk("flush_lk_dropped", 32'(lk_done), 32'd0);
      for (int i = 0; i < NS; i++) cycle(1, 3'd1, 7'h44, 1, 2'b01, 3'd1, 7'h44, 1, 0);
      chk("ready_after_flush", 32'(ready), 32'd1);
      for (int i = 0; i < NS; i++) begin
         cycle(1, AW'(i), 7'h44, 0, '0, '0, '0, 0, 0);
         chk($sformatf("post_flush_miss%0d", i), 32'(hit), 32'd0);
      end

      // Reset in the middle of a lookup result.
      cycle(0, '0, '0, 1, 2'b10, 3'd7, 7'h77, 1, 0);
      cycle(1, 3'd7, 7'h77, 0, '0, '0, '0, 0, 0);
      chk("pre_rst_hit", 32'(hit), 32'd1);
      apply_reset();
      idle(NS);

      // Reset in the middle of a sweep restarts it from set 0.
      cycle(0, '0, '0, 0, '0, '0, '0, 0, 1);
      idle(3);
      apply_reset();
      idle(NS);
      idle(1);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 1) == 1), AW'($urandom_range(0, NS - 1)), TW'($urandom_range(0, 3)),
               ($urandom_range(0, 9) < 5), NW'($urandom_range(0, 3)), AW'($urandom_range(0, NS - 1)),
               TW'($urandom_range(0, 3)), ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 2));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
